// File: rtl/fetch_pkg.sv
// Shared encodings, field positions and branch offsets for the fetch stage.
// Pure constants and types; no timing of its own.
// No flow control; consumed by combinational decode logic.
package fetch_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Instruction field bit positions within the 9-bit word
   localparam int OP_HI  = 8;
   localparam int OP_LO  = 7;
   localparam int FN_HI  = 6;
   localparam int FN_LO  = 5;
   localparam int IMM_HI = 2;
   localparam int IMM_LO = 0;

   // OP / Function encodings
   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [1:0] FN_ADD   = 2'b00;
   localparam logic [2:0] OP_BEQ   = 3'd0;
   localparam logic [1:0] FN_BEQ   = 2'b01;
   localparam logic [2:0] OP_HALT  = 3'd3;
   localparam logic [1:0] FN_HALT  = 2'b11;

   // Branch offsets, index 0 in the low byte: {+2,+3,+4,-1,-2,-3,-4,-8}
   localparam logic [7:0][7:0] BR_LUT = {
      8'hF8, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h04, 8'h03, 8'h02
   };

endpackage

// File: rtl/branch_lut.sv
// Maps the 3-bit branch index to its signed 8-bit PC offset.
// Purely combinational, zero latency.
// No flow control.
module branch_lut
   import fetch_pkg::*;
(
   input  logic [2:0] i_idx,
   output logic [7:0] o_off
);

   assign o_off = BR_LUT[i_idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction decode, BEQ resolution and start/halt control.
// Single cycle: the instruction at PC completes at the next rising edge.
// Stall freezes PC, counter and FSM (and drops Start); Valid low while stalled.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic [8:0]       Instr,
   input  logic             Zero,
   output logic [PC_W-1:0]  PC,
   output logic [2:0]       OP,
   output logic [1:0]       Function,
   output logic [7:0]       Immediate,
   output logic             Valid,
   output logic             BranchTaken,
   output logic             Done,
   output logic [CNT_W-1:0] InstrCount
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [7:0]        w_off;
   logic [PC_W-1:0]   w_off_ext;
   logic              w_is_halt;
   logic              w_is_beq;
   logic [1:0]        w_unused_bits;

   // Bits [4:3] carry no meaning for this stage
   assign w_unused_bits = Instr[4:3];

   assign OP        = {1'b0, Instr[OP_HI:OP_LO]};
   assign Function  = Instr[FN_HI:FN_LO];
   assign Immediate = {5'b0, Instr[IMM_HI:IMM_LO]};

   assign w_is_halt = (OP == OP_HALT) && (Function == FN_HALT);
   assign w_is_beq  = (OP == OP_BEQ)  && (Function == FN_BEQ);

   assign Valid       = (r_state == ST_RUN) && !Stall;
   assign BranchTaken = Valid && w_is_beq && Zero;
   assign Done        = (r_state == ST_HALT);
   assign PC          = r_pc;
   assign InstrCount  = r_cnt;

   branch_lut u_branch_lut (
      .i_idx (Instr[IMM_HI:IMM_LO]),
      .o_off (w_off)
   );

   // Offset is signed; extend to PC width so the add wraps modulo 2^PC_W
   assign w_off_ext = PC_W'($signed(w_off));

   // State, PC and counter registers with asynchronous reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, next-PC and retire-count logic; Stall overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      if (!Stall) begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (Start) begin
                  w_state_nxt = ST_RUN;
                  w_pc_nxt    = '0;
                  w_cnt_nxt   = '0;
               end
            end
            ST_RUN: begin
               if (w_is_halt) begin
                  w_state_nxt = ST_HALT;
               end else begin
                  w_pc_nxt = BranchTaken ? (r_pc + w_off_ext) : (r_pc + PC_W'(1));
                  if (r_cnt != {CNT_W{1'b1}})
                     w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule
